// File: rtl/l2_cache_if.sv
// Command, response and shared-bus signals of the L2 tag/MESI controller.
interface l2_cache_if #(
    parameter int unsigned ADDR_BITS = 32
) ();
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [3:0]           cmd;
    logic [ADDR_BITS-1:0] addr;
    logic                 rsp_valid;
    logic                 rsp_hit;
    logic [1:0]           rsp_mesi;
    logic                 bus_op_valid;
    logic [1:0]           bus_op;
    logic [ADDR_BITS-1:0] bus_addr;
    logic [1:0]           snoop_in;
    logic [1:0]           snoop_out;

    modport master (
        output cmd_valid, cmd, addr, snoop_in,
        input  cmd_ready, rsp_valid, rsp_hit, rsp_mesi, bus_op_valid, bus_op, bus_addr, snoop_out
    );

    modport slave (
        input  cmd_valid, cmd, addr, snoop_in,
        output cmd_ready, rsp_valid, rsp_hit, rsp_mesi, bus_op_valid, bus_op, bus_addr, snoop_out
    );
endinterface

// File: rtl/l2_cache_ctrl.sv
// Set-associative L2 tag/MESI controller with tree-PLRU replacement and a set-clearing sweep.
// Define L2_STATS_EN to build the saturating hit/miss/read/write statistics counters.
module l2_cache_ctrl #(
    parameter int unsigned WAYS        = 8,
    parameter int unsigned ADDR_BITS   = 32,
    parameter int unsigned INDEX_BITS  = 14,
    parameter int unsigned OFFSET_BITS = 6,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    l2_cache_if.slave            ctrl,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] read_count,
    output logic [CNT_WIDTH-1:0] write_count
);
    localparam int unsigned SETS      = 2 ** INDEX_BITS;
    localparam int unsigned LINE_BITS = ADDR_BITS - OFFSET_BITS;
    localparam int unsigned TAG_BITS  = LINE_BITS - INDEX_BITS;
    localparam int unsigned WAY_BITS  = $clog2(WAYS);

    localparam logic [1:0] MesiI    = 2'd0;
    localparam logic [1:0] MesiS    = 2'd1;
    localparam logic [1:0] MesiE    = 2'd2;
    localparam logic [1:0] MesiM    = 2'd3;
    localparam logic [1:0] BusRead  = 2'd0;
    localparam logic [1:0] BusWrite = 2'd1;
    localparam logic [1:0] BusInv   = 2'd2;
    localparam logic [1:0] BusRwim  = 2'd3;
    localparam logic [1:0] SnpHit   = 2'd0;
    localparam logic [1:0] SnpHitm  = 2'd1;
    localparam logic [1:0] SnpNohit = 2'd2;

    typedef enum logic [2:0] {StClear, StIdle, StLookup, StWback, StFill, StResp} state_e;
    state_e state_q, state_d;

    logic [INDEX_BITS-1:0] clr_idx_q, clr_idx_d;
    logic                  clr_rsp_q, clr_rsp_d;
    logic [3:0]            cmd_q, cmd_d;
    logic [LINE_BITS-1:0]  line_q, line_d, wb_line_q, wb_line_d;
    logic [WAY_BITS-1:0]   way_q, way_d;
    logic [1:0]            fill_op_q, fill_op_d, mesi_q, mesi_d, snp_q, snp_d;
    logic                  hit_q, hit_d;

    logic [WAYS-1:0][1:0]          st_mem   [SETS];
    logic [WAYS-1:0][TAG_BITS-1:0] tag_mem  [SETS];
    logic [WAYS-1:0]               plru_mem [SETS];

    logic [INDEX_BITS-1:0]         idx, w_idx;
    logic [TAG_BITS-1:0]           tag;
    logic [WAYS-1:0][1:0]          set_st, st_wdata;
    logic [WAYS-1:0][TAG_BITS-1:0] set_tag, tag_wdata;
    logic [WAYS-1:0]               set_plru, plru_wdata;
    logic                          st_we, tag_we, plru_we;
    logic                          hit, inv_found, proc_cmd;
    logic [WAY_BITS-1:0]           hit_way, inv_way, victim;
    logic [1:0]                    hit_st, fill_st;

    // Tree nodes are heap-ordered; a node bit of 0 points the victim search at the lower half.
    function automatic logic [WAY_BITS-1:0] plru_victim(input logic [WAYS-1:0] t);
        int unsigned n;
        n = 0;
        for (int l = 0; l < int'(WAY_BITS); l++) n = 2 * n + 1 + 32'(1'(t >> n));
        return WAY_BITS'(n - (WAYS - 1));
    endfunction

    function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] t,
                                                   input logic [WAY_BITS-1:0] way);
        logic [WAYS-1:0] r;
        int unsigned     n;
        logic            dir;
        r = t;
        n = 0;
        for (int l = 0; l < int'(WAY_BITS); l++) begin
            dir              = 1'(way >> (WAY_BITS - 1 - l));
            r[WAY_BITS'(n)]  = ~dir;
            n                = 2 * n + 1 + 32'(dir);
        end
        return r;
    endfunction

    assign idx      = line_q[INDEX_BITS-1:0];
    assign tag      = line_q[LINE_BITS-1 -: TAG_BITS];
    assign set_st   = st_mem[idx];
    assign set_tag  = tag_mem[idx];
    assign set_plru = plru_mem[idx];
    assign proc_cmd = (cmd_q <= 4'd2);

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (set_st[WAY_BITS'(w)] != MesiI && set_tag[WAY_BITS'(w)] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (set_st[WAY_BITS'(w)] == MesiI) begin
                inv_found = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
        end
    end

    assign hit_st  = set_st[hit_way];
    assign victim  = inv_found ? inv_way : plru_victim(set_plru);
    assign fill_st = (fill_op_q != BusRead) ? MesiM :
                     (ctrl.snoop_in == SnpNohit) ? MesiE : MesiS;

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        clr_rsp_d    = clr_rsp_q;
        cmd_d        = cmd_q;
        line_d       = line_q;
        wb_line_d    = wb_line_q;
        way_d        = way_q;
        fill_op_d    = fill_op_q;
        hit_d        = hit_q;
        mesi_d       = mesi_q;
        snp_d        = snp_q;
        w_idx        = idx;
        st_we        = 1'b0;
        tag_we       = 1'b0;
        plru_we      = 1'b0;
        st_wdata     = set_st;
        tag_wdata    = set_tag;
        plru_wdata   = set_plru;
        ctrl.cmd_ready    = 1'b0;
        ctrl.rsp_valid    = 1'b0;
        ctrl.rsp_hit      = 1'b0;
        ctrl.rsp_mesi     = 2'd0;
        ctrl.snoop_out    = 2'd0;
        ctrl.bus_op_valid = 1'b0;
        ctrl.bus_op       = 2'd0;
        ctrl.bus_addr     = '0;
        unique case (state_q)
            StClear: begin
                w_idx      = clr_idx_q;
                st_we      = 1'b1;
                st_wdata   = '0;
                plru_we    = 1'b1;
                plru_wdata = '0;
                clr_idx_d  = clr_idx_q + 1'b1;
                if (clr_idx_q == '1) state_d = clr_rsp_q ? StResp : StIdle;
            end
            StIdle: begin
                ctrl.cmd_ready = 1'b1;
                if (ctrl.cmd_valid) begin
                    cmd_d  = ctrl.cmd;
                    line_d = ctrl.addr[ADDR_BITS-1:OFFSET_BITS];
                    hit_d  = 1'b0;
                    mesi_d = MesiI;
                    snp_d  = SnpNohit;
                    if (ctrl.cmd <= 4'd6) begin
                        state_d = StLookup;
                    end else if (ctrl.cmd == 4'd8) begin
                        state_d   = StClear;
                        clr_idx_d = '0;
                        clr_rsp_d = 1'b1;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StLookup: begin
                hit_d     = hit;
                way_d     = victim;
                wb_line_d = {set_tag[victim], idx};
                state_d   = StResp;
                case (cmd_q)
                    4'd0, 4'd1, 4'd2: begin
                        if (hit && !(cmd_q == 4'd1 && hit_st == MesiS)) begin
                            mesi_d            = (cmd_q == 4'd1) ? MesiM : hit_st;
                            st_we             = 1'b1;
                            st_wdata[hit_way] = (cmd_q == 4'd1) ? MesiM : hit_st;
                            plru_we           = 1'b1;
                            plru_wdata        = plru_touch(set_plru, hit_way);
                        end else begin
                            fill_op_d = hit ? BusInv : (cmd_q == 4'd1) ? BusRwim : BusRead;
                            if (hit) way_d = hit_way;
                            state_d = (!hit && set_st[victim] == MesiM) ? StWback : StFill;
                        end
                    end
                    4'd4, 4'd6: begin
                        if (hit) begin
                            mesi_d            = (cmd_q == 4'd4) ? MesiS : MesiI;
                            st_we             = 1'b1;
                            st_wdata[hit_way] = (cmd_q == 4'd4) ? MesiS : MesiI;
                            snp_d             = (hit_st == MesiM) ? SnpHitm : SnpHit;
                            wb_line_d         = line_q;
                            if (hit_st == MesiM) state_d = StWback;
                        end
                    end
                    4'd3, 4'd5: begin
                        if (hit) begin
                            snp_d  = SnpHit;
                            mesi_d = hit_st;
                            if (cmd_q == 4'd3 && hit_st == MesiS) begin
                                mesi_d            = MesiI;
                                st_we             = 1'b1;
                                st_wdata[hit_way] = MesiI;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            StWback: begin
                ctrl.bus_op_valid = 1'b1;
                ctrl.bus_op       = BusWrite;
                ctrl.bus_addr     = {wb_line_q, {OFFSET_BITS{1'b0}}};
                state_d           = proc_cmd ? StFill : StResp;
            end
            StFill: begin
                ctrl.bus_op_valid = 1'b1;
                ctrl.bus_op       = fill_op_q;
                ctrl.bus_addr     = {line_q, {OFFSET_BITS{1'b0}}};
                st_we             = 1'b1;
                st_wdata[way_q]   = fill_st;
                tag_we            = 1'b1;
                tag_wdata[way_q]  = tag;
                plru_we           = 1'b1;
                plru_wdata        = plru_touch(set_plru, way_q);
                mesi_d            = fill_st;
                state_d           = StResp;
            end
            StResp: begin
                ctrl.rsp_valid = 1'b1;
                ctrl.rsp_hit   = hit_q;
                ctrl.rsp_mesi  = mesi_q;
                ctrl.snoop_out = snp_q;
                clr_rsp_d      = 1'b0;
                state_d        = StIdle;
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (st_we)   st_mem[w_idx]   <= st_wdata;
        if (tag_we)  tag_mem[w_idx]  <= tag_wdata;
        if (plru_we) plru_mem[w_idx] <= plru_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            clr_rsp_q <= 1'b0;
            cmd_q     <= '0;
            line_q    <= '0;
            wb_line_q <= '0;
            way_q     <= '0;
            fill_op_q <= '0;
            hit_q     <= 1'b0;
            mesi_q    <= '0;
            snp_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            clr_rsp_q <= clr_rsp_d;
            cmd_q     <= cmd_d;
            line_q    <= line_d;
            wb_line_q <= wb_line_d;
            way_q     <= way_d;
            fill_op_q <= fill_op_d;
            hit_q     <= hit_d;
            mesi_q    <= mesi_d;
            snp_q     <= snp_d;
        end
    end

`ifdef L2_STATS_EN
    logic stat_clr, stat_look;
    assign stat_clr  = (state_q == StIdle) && ctrl.cmd_valid && (ctrl.cmd == 4'd8);
    assign stat_look = (state_q == StLookup) && proc_cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count   <= '0;
            miss_count  <= '0;
            read_count  <= '0;
            write_count <= '0;
        end else if (stat_clr) begin
            hit_count   <= '0;
            miss_count  <= '0;
            read_count  <= '0;
            write_count <= '0;
        end else if (stat_look) begin
            if (cmd_q != 4'd1 && read_count != '1)  read_count  <= read_count + 1'b1;
            if (cmd_q == 4'd1 && write_count != '1) write_count <= write_count + 1'b1;
            if (hit && hit_count != '1)             hit_count   <= hit_count + 1'b1;
            if (!hit && miss_count != '1)           miss_count  <= miss_count + 1'b1;
        end
    end
`else
    assign hit_count   = '0;
    assign miss_count  = '0;
    assign read_count  = '0;
    assign write_count = '0;
`endif
endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Scoreboard bench for l2_cache_ctrl: directed commands queue expected responses and bus ops.
module tb_l2_cache_ctrl;
    localparam int unsigned WAYS        = 8;
    localparam int unsigned ADDR_BITS   = 32;
    localparam int unsigned INDEX_BITS  = 4;
    localparam int unsigned OFFSET_BITS = 6;
    localparam int unsigned CNT_WIDTH   = 32;
    localparam int unsigned SETS        = 16;

    localparam logic [1:0] I = 2'd0, S = 2'd1, E = 2'd2, M = 2'd3;
    localparam logic [1:0] RD = 2'd0, WR = 2'd1, INV = 2'd2, RWIM = 2'd3;
    localparam logic [1:0] HIT = 2'd0, HITM = 2'd1, NOHIT = 2'd2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2_cache_if #(.ADDR_BITS(ADDR_BITS)) cif ();
    logic [CNT_WIDTH-1:0] hit_count, miss_count, read_count, write_count;

    l2_cache_ctrl #(
        .WAYS(WAYS), .ADDR_BITS(ADDR_BITS), .INDEX_BITS(INDEX_BITS),
        .OFFSET_BITS(OFFSET_BITS), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ctrl(cif),
        .hit_count(hit_count),
        .miss_count(miss_count),
        .read_count(read_count),
        .write_count(write_count)
    );

    typedef struct {
        logic        hit;
        logic [1:0]  mesi;
        logic [1:0]  snp;
        int unsigned lat;
        int unsigned acc;
    } rsp_t;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];
    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Monitor: compares every response and bus operation against the queued expectation.
    always @(negedge clk) begin
        rsp_t r;
        bus_t b;
        if (cif.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                fail_now("rsp_unexpected");
            end else begin
                r = rsp_q.pop_front();
                check("rsp_hit", cif.rsp_hit, r.hit);
                check("rsp_mesi", cif.rsp_mesi, r.mesi);
                check("snoop_out", cif.snoop_out, r.snp);
                check("rsp_latency", cyc - r.acc, r.lat);
            end
        end
        if (cif.bus_op_valid) begin
            if (bus_q.size() == 0) begin
                fail_now("bus_unexpected");
            end else begin
                b = bus_q.pop_front();
                check("bus_op", cif.bus_op, b.op);
                check("bus_addr", cif.bus_addr, b.addr);
            end
        end
    end

    task automatic expect_bus(input logic [1:0] op, input logic [31:0] a);
        bus_t b;
        b.op   = op;
        b.addr = a;
        bus_q.push_back(b);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cif.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [1:0] sin,
                         input logic eh, input logic [1:0] em, input logic [1:0] es,
                         input int unsigned el);
        rsp_t e;
        int   n;
        @(negedge clk);
        wait_ready();
        if (!cif.cmd_ready) begin
            fail_now("cmd_ready_timeout");
            bus_q.delete();
        end else begin
            cif.cmd       = c;
            cif.addr      = a;
            cif.snoop_in  = sin;
            cif.cmd_valid = 1'b1;
            e.hit  = eh;
            e.mesi = em;
            e.snp  = es;
            e.lat  = el;
            e.acc  = cyc;
            rsp_q.push_back(e);
            @(posedge clk);
            #1 cif.cmd_valid = 1'b0;
            n = 0;
            while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 64) begin
                @(negedge clk);
                n++;
            end
            if (rsp_q.size() != 0 || bus_q.size() != 0) begin
                fail_now("response_timeout");
                rsp_q.delete();
                bus_q.delete();
            end
        end
    endtask

    task automatic sweep_check();
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!cif.cmd_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sweep_cycles", n, SETS);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd       = 4'd0;
        cif.addr      = '0;
        cif.snoop_in  = NOHIT;
        #12;
        check("reset_outputs", {cif.cmd_ready, cif.rsp_valid, cif.bus_op_valid, cif.rsp_hit,
                                cif.rsp_mesi, cif.snoop_out, cif.bus_op, cif.bus_addr}, 0);
        sweep_check();

        // Fill, hit, shared fill, upgrade, snoops.
        expect_bus(RD, 32'h0000_1000);
        issue(4'd0, 32'h0000_1000, NOHIT, 1'b0, E, NOHIT, 3);
        issue(4'd0, 32'h0000_1000, NOHIT, 1'b1, E, NOHIT, 2);
        expect_bus(RD, 32'h0000_2040);
        issue(4'd0, 32'h0000_2040, HITM, 1'b0, S, NOHIT, 3);
        expect_bus(INV, 32'h0000_2040);
        issue(4'd1, 32'h0000_2040, NOHIT, 1'b1, M, NOHIT, 3);
        expect_bus(WR, 32'h0000_2040);
        issue(4'd4, 32'h0000_2040, NOHIT, 1'b1, S, HITM, 3);
        issue(4'd6, 32'h0000_2040, NOHIT, 1'b1, I, HIT, 2);
        expect_bus(RD, 32'h0000_2040);
        issue(4'd0, 32'h0000_2067, NOHIT, 1'b0, E, NOHIT, 3);
        issue(4'd2, 32'h0000_2040, NOHIT, 1'b1, E, NOHIT, 2);
        issue(4'd3, 32'h0000_1000, NOHIT, 1'b1, E, HIT, 2);
        issue(4'd4, 32'h0000_1000, NOHIT, 1'b1, S, HIT, 2);
        issue(4'd3, 32'h0000_1000, NOHIT, 1'b1, I, HIT, 2);
        expect_bus(RD, 32'h0000_1000);
        issue(4'd2, 32'h0000_1000, HIT, 1'b0, S, NOHIT, 3);
        issue(4'd5, 32'h0000_3000, NOHIT, 1'b0, I, NOHIT, 2);
        issue(4'd6, 32'h0000_3000, NOHIT, 1'b0, I, NOHIT, 2);
        issue(4'd9, 32'h0000_1000, NOHIT, 1'b0, I, NOHIT, 1);
        issue(4'd7, 32'h0000_1000, NOHIT, 1'b0, I, NOHIT, 1);
        issue(4'd8, 32'h0000_0000, NOHIT, 1'b0, I, NOHIT, SETS + 1);

        // Nine write misses into set 0; the ninth evicts the PLRU victim (way 0, tag 1).
        for (int k = 1; k <= 9; k++) begin
            if (k == 9) expect_bus(WR, 32'h0000_0400);
            expect_bus(RWIM, 32'(k) * 32'h400);
            issue(4'd1, 32'(k) * 32'h400, NOHIT, 1'b0, M, NOHIT, (k == 9) ? 4 : 3);
        end
        // Tree now points at way 4 (tag 5).
        expect_bus(WR, 32'h0000_1400);
        expect_bus(RD, 32'h0000_0400);
        issue(4'd0, 32'h0000_0400, NOHIT, 1'b0, E, NOHIT, 4);
        issue(4'd0, 32'h0000_2400, NOHIT, 1'b1, M, NOHIT, 2);

        // Reset while the fill is on the bus.
        @(negedge clk);
        wait_ready();
        cif.cmd       = 4'd0;
        cif.addr      = 32'h0000_8040;
        cif.snoop_in  = NOHIT;
        cif.cmd_valid = 1'b1;
        @(posedge clk);
        #1 cif.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("fill_in_progress", {cif.bus_op_valid, cif.bus_op}, {1'b1, RD});
        #1 rst_n = 1'b0;
        #1;
        check("abort_outputs", {cif.cmd_ready, cif.rsp_valid, cif.bus_op_valid, cif.rsp_hit,
                                cif.rsp_mesi, cif.snoop_out, cif.bus_addr}, 0);
        sweep_check();
        expect_bus(RD, 32'h0000_8040);
        issue(4'd0, 32'h0000_8040, NOHIT, 1'b0, E, NOHIT, 3);

`ifdef L2_STATS_EN
        issue(4'd0, 32'h0000_8040, NOHIT, 1'b1, E, NOHIT, 2);
        expect_bus(RD, 32'h0000_1040);
        issue(4'd0, 32'h0000_1040, NOHIT, 1'b0, E, NOHIT, 3);
        expect_bus(RWIM, 32'h0000_3000);
        issue(4'd1, 32'h0000_3000, NOHIT, 1'b0, M, NOHIT, 3);
        check("read_count", read_count, 3);
        check("write_count", write_count, 1);
        check("hit_count", hit_count, 1);
        check("miss_count", miss_count, 3);
        issue(4'd8, 32'h0000_0000, NOHIT, 1'b0, I, NOHIT, SETS + 1);
        check("counters_cleared", {read_count, write_count, hit_count, miss_count}, 0);
`else
        check("counters_tied", {read_count, write_count, hit_count, miss_count}, 0);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
